// File: rtl/load_store_unit.sv
// MIPS32 memory-access stage: drives a word-wide req/ack data-memory port for
// byte/halfword/word loads and stores, and returns aligned, extended load data.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic        addrError,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic        bus_err_q;

    logic        supported, misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic        accept, timeout;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // Request decode straight off the EX inputs; only consumed in IDLE.
    always_comb begin
        supported  = 1'b1;
        misaligned = 1'b0;
        be_dec     = 4'b0000;
        wdata_dec  = 32'h0;
        case (opcode)
            OP_LB, OP_LBU: be_dec = 4'b0001 << addr[1:0];
            OP_LH, OP_LHU: begin
                be_dec     = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            OP_LW: begin
                be_dec     = 4'b1111;
                misaligned = |addr[1:0];
            end
            OP_SB: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{storeData[7:0]}};
            end
            OP_SH: begin
                be_dec     = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
                wdata_dec  = {2{storeData[15:0]}};
            end
            OP_SW: begin
                be_dec     = 4'b1111;
                misaligned = |addr[1:0];
                wdata_dec  = storeData;
            end
            default: supported = 1'b0;
        endcase
    end

    assign accept  = (state == IDLE) && start && supported;
    // Ack in the expiry cycle takes priority over the timeout.
    assign timeout = (state == ACCESS) && !memAck && (wait_cnt == CNT_LAST);

    // Lane select uses the latched address offset from the request.
    always_comb begin
        lane_byte = memRdata[8*off_q +: 8];
        lane_half = off_q[1] ? memRdata[31:16] : memRdata[15:0];
        case (op_q)
            OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_ext = {24'h0, lane_byte};
            OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_ext = {16'h0, lane_half};
            default: load_ext = memRdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misaligned ? ERR : ACCESS;
            ACCESS:  if (memAck || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = accept || (state == ACCESS) || (state == ERR);
    assign done      = (state == RESP) || (state == ERR);
    assign addrError = (state == ERR);
    assign busError  = (state == RESP) && bus_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'h0;
            op_q      <= 6'h0;
            off_q     <= 2'b00;
            bus_err_q <= 1'b0;
            loadData  <= 32'h0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 32'h0;
            memBe     <= 4'b0000;
            memWdata  <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    bus_err_q <= 1'b0;
                    if (!misaligned) begin
                        op_q     <= opcode;
                        off_q    <= addr[1:0];
                        wait_cnt <= 8'h0;
                        memReq   <= 1'b1;
                        memWe    <= opcode[3];
                        memAddr  <= {addr[31:2], 2'b00};
                        memBe    <= be_dec;
                        memWdata <= wdata_dec;
                    end
                end
                ACCESS: begin
                    if (memAck || timeout) begin
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        memAddr  <= 32'h0;
                        memBe    <= 4'b0000;
                        memWdata <= 32'h0;
                    end
                    if (memAck) begin
                        if (!op_q[3]) loadData <= load_ext;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory requests
// and responses into queues; a negedge monitor pops and compares them.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset, start, memAck;
    logic [5:0]  opcode;
    logic [31:0] addr, storeData, memRdata;
    logic        busy, done, addrError, busError, memReq, memWe;
    logic [31:0] loadData, memAddr, memWdata;
    logic [3:0]  memBe;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .addr(addr), .storeData(storeData), .busy(busy), .done(done),
        .loadData(loadData), .addrError(addrError), .busError(busError),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
        .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] a; logic [3:0] be; logic we; logic [31:0] wd; } req_t;
    typedef struct { logic [31:0] ld; logic ae; logic be; } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        req_prev = 1'b0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: request fields on memReq rising, response fields on done.
    always @(negedge clock) begin
        if (!reset) begin
            if (memReq && !req_prev) begin
                if (req_q.size() == 0) chk("unexpected_memReq", 32'd1, 32'd0);
                else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("memAddr", memAddr, r.a);
                    chk("memBe", {28'h0, memBe}, {28'h0, r.be});
                    chk("memWe", {31'h0, memWe}, {31'h0, r.we});
                    chk("memWdata", memWdata, r.wd);
                end
            end
            if (done) begin
                if (rsp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("loadData", loadData, e.ld);
                    chk("addrError", {31'h0, addrError}, {31'h0, e.ae});
                    chk("busError", {31'h0, busError}, {31'h0, e.be});
                end
            end
        end
        req_prev = memReq;
    end

    // One access: start in cycle 0, ack driven in cycle ack_at (0 = never).
    task automatic run(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                       input int exp_done, input int exp_req, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] ld, input logic ae,
                       input logic berr);
        int cyc, reqs;
        bit got;
        if (exp_req > 0) req_q.push_back('{{a[31:2], 2'b00}, be, op[3], wd});
        rsp_q.push_back('{ld, ae, berr});
        @(negedge clock);
        start = 1'b1; opcode = op; addr = a; storeData = sd; memRdata = rd;
        #1 chk({name, "_busy"}, {31'h0, busy}, 32'd1);
        @(posedge clock); #1 start = 1'b0;
        cyc = 1; reqs = 0; got = 0;
        while (cyc <= 300 && !got) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                chk({name, "_done_cycle"}, cyc, exp_done);
            end else begin
                if (memReq) reqs++;
                memAck = (cyc == ack_at);
            end
            @(posedge clock); #1 memAck = 1'b0;
            cyc++;
        end
        if (!got) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        chk({name, "_req_cycles"}, reqs, exp_req);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; memAck = 1'b0; opcode = 6'h0;
        addr = 32'h0; storeData = 32'h0; memRdata = 32'h0;
        repeat (2) @(negedge clock);
        chk("rst_busy_done", {30'h0, busy, done}, 32'd0);
        chk("rst_err", {30'h0, addrError, busError}, 32'd0);
        chk("rst_memReq_We", {30'h0, memReq, memWe}, 32'd0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memBe", {28'h0, memBe}, 32'h0);
        chk("rst_memWdata", memWdata, 32'h0);
        chk("rst_loadData", loadData, 32'h0);
        reset = 1'b0;

        run("lw",  6'b100011, 32'h00001004, 32'h0, 32'hDEADBEEF, 1, 2, 1, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0);
        run("lb",  6'b100000, 32'h00002003, 32'h0, 32'h80FF7F01, 1, 2, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 0);
        run("lbu", 6'b100100, 32'h00002003, 32'h0, 32'h80FF7F01, 1, 2, 1, 4'b1000, 32'h0, 32'h00000080, 0, 0);
        run("lh",  6'b100001, 32'h00002002, 32'h0, 32'h80FF7F01, 1, 2, 1, 4'b1100, 32'h0, 32'hFFFF80FF, 0, 0);
        run("lhu", 6'b100101, 32'h00002002, 32'h0, 32'h80FF7F01, 1, 2, 1, 4'b1100, 32'h0, 32'h000080FF, 0, 0);
        run("lb0", 6'b100000, 32'h00002001, 32'h0, 32'h80FF7F01, 1, 2, 1, 4'b0010, 32'h0, 32'h0000007F, 0, 0);
        last_load = 32'h0000007F;
        run("sb",  6'b101000, 32'h00003001, 32'h123456AB, 32'h0, 1, 2, 1, 4'b0010, 32'hABABABAB, last_load, 0, 0);
        run("sh",  6'b101001, 32'h00003002, 32'h0000CAFE, 32'h0, 1, 2, 1, 4'b1100, 32'hCAFECAFE, last_load, 0, 0);
        run("sw",  6'b101011, 32'h00003008, 32'h11223344, 32'h0, 2, 3, 2, 4'b1111, 32'h11223344, last_load, 0, 0);
        run("lh_mis", 6'b100001, 32'h00001001, 32'h0, 32'h0, 0, 1, 0, 4'b0, 32'h0, last_load, 1, 0);
        run("sw_mis", 6'b101011, 32'h00001002, 32'h0, 32'h0, 0, 1, 0, 4'b0, 32'h0, last_load, 1, 0);
        run("lw_to",  6'b100011, 32'h00004000, 32'h0, 32'h55555555, 0, TO + 1, TO, 4'b1111, 32'h0, last_load, 0, 1);
        run("lw_ack4", 6'b100011, 32'h00004000, 32'h0, 32'h12345678, TO, TO + 1, TO, 4'b1111, 32'h0, 32'h12345678, 0, 0);
        last_load = 32'h12345678;

        // Unsupported opcode: no stall, no request, no done.
        @(negedge clock);
        start = 1'b1; opcode = 6'b000000; addr = 32'h00005000;
        #1 chk("unsup_busy", {31'h0, busy}, 32'd0);
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        chk("unsup_quiet", {30'h0, memReq, done}, 32'd0);

        // Reset in cycle 2 of an outstanding SW.
        req_q.push_back('{32'h00006000, 4'b1111, 1'b1, 32'hA5A5A5A5});
        @(negedge clock);
        start = 1'b1; opcode = 6'b101011; addr = 32'h00006000; storeData = 32'hA5A5A5A5;
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        #1 chk("rst_mid_outputs", {29'h0, memReq, busy, done}, 32'd0);
        chk("rst_mid_loadData", loadData, 32'h0);
        @(negedge clock); reset = 1'b0;

        run("lw_after", 6'b100011, 32'h00007000, 32'h0, 32'hCAFEF00D, 1, 2, 1, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 0);

        repeat (3) @(negedge clock);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the MIPS32 pipeline, directly downstream of the ALU. It takes the effective address produced by the ALU for load and store opcodes (rs + sign-extended offset) together with the store data, and drives a word-wide data-memory request/acknowledge handshake. It then returns byte/halfword/word load data, aligned and extended, to writeback. It stalls the pipeline while an access is outstanding, and flags misaligned addresses and bus timeouts.

## Interface
- ACK_TIMEOUT, 255: maximum cycles `memReq` may wait for `memAck` before the access is aborted (1..255).
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle request from EX; sampled only in IDLE.
- opcode  in  6  LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- addr  in  32  effective address (ALU result).
- storeData  in  32  rt value; low byte/halfword used for SB/SH.
- busy  out  1  pipeline stall.
- done  out  1  one-cycle completion pulse.
- loadData  out  32  aligned, extended load result; valid while `done`=1, held until the next load completes.
- addrError  out  1  one-cycle pulse, with `done`, on a misaligned access.
- busError  out  1  one-cycle pulse, with `done`, on an ack timeout.
- memReq  out  1  request; held until `memAck`.
- memWe  out  1  1 = write.
- memAddr  out  32  word address {addr[31:2], 2'b00}.
- memBe  out  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- memWdata  out  32  write data, replicated across lanes.
- memAck  in  1  memory accepted write / returned read data this cycle.
- memRdata  in  32  read data, valid when `memAck`=1.

## Operation
- Byte order is little-endian: the byte at addr[1:0]=k is in lane k.
- The FSM has four states: IDLE, ACCESS, RESP, ERR.
- IDLE, `start`=1, supported opcode:
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): go to ERR.
  - Otherwise: latch opcode, addr[1:0] and store lanes; drive memReq/memWe/memAddr/memBe/memWdata; go to ACCESS.
- IDLE, `start`=1, unsupported opcode: ignored. Stay IDLE; no outputs change.
- `start` outside IDLE is ignored. EX must hold its instruction while `busy`=1.
- ACCESS:
  - `memReq`=1 with all mem outputs stable.
  - On `memAck`: loads capture memRdata; go to RESP.
  - On timeout: go to RESP with busError pending and loadData not updated.
- RESP: `done`=1 (plus `busError` if pending). Go to IDLE.
- ERR: `done`=1 and `addrError`=1. No memory request is issued. Go to IDLE.
- Byte enables:
  - SB, LB, LBU: 0001 << addr[1:0].
  - SH, LH, LHU: addr[1] ? 1100 : 0011.
  - LW, SW: 1111.
- Write data:
  - SB: {4{storeData[7:0]}}.
  - SH: {2{storeData[15:0]}}.
  - SW: storeData.
  - Loads: 0.
- Loads always read the full word. The lane is selected by the latched addr[1:0]:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: word as-is.
- Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle without `memAck`. When the count reaches ACK_TIMEOUT, drop `memReq` and move to RESP. `memAck` in the expiry cycle wins: normal completion, no busError.
- `memAck` while `memReq`=0 is ignored.

## Timing
- Reset values: state IDLE; busy, done, addrError, busError, memReq, memWe, memBe, memAddr, memWdata = 0; loadData = 0. Reset asserted mid-access drops `memReq` immediately (asynchronously) and discards the access.
- `busy` = (IDLE & start & supported opcode) | ACCESS | ERR. It is combinational on `start`, so EX stalls in the same cycle it issues. `busy`=0 in RESP, so the pipeline advances with `done`.
- `memReq` and the other mem outputs are registered and rise one cycle after `start` (cycle 1).
- `memAck` in cycle 1 gives `done` in cycle 2. Each extra wait cycle adds one cycle of latency.
- Misaligned access: `done`+`addrError` in cycle 1.
- Timeout: `memReq` is high for ACK_TIMEOUT cycles (cycles 1..ACK_TIMEOUT); `done`+`busError` follow in cycle ACK_TIMEOUT+1.
- Back-to-back: a new `start` is accepted in the cycle after RESP/ERR (IDLE), giving a throughput of one access per 3 cycles minimum.

## Test plan
- LW addr 0x00001004, memRdata 0xDEADBEEF, ack in cycle 1 -> memAddr 0x00001004, memBe 1111, memWe 0, done in cycle 2, loadData 0xDEADBEEF.
- LB addr 0x00002003, memRdata 0x80FF7F01 -> memBe 1000, loadData 0xFFFFFF80. Same with LBU -> 0x00000080. LHU addr 0x2002 -> 0x000080FF.
- SB addr 0x00003001, storeData 0x123456AB -> memWe 1, memBe 0010, memWdata 0xABABABAB. SH addr 0x3002, storeData 0x0000CAFE -> memBe 1100, memWdata 0xCAFECAFE.
- LH addr 0x00001001 -> no memReq; done+addrError in cycle 1. SW addr 0x1002 -> same.
- ACK_TIMEOUT=4, LW, memAck never asserted -> memReq high cycles 1-4, done+busError in cycle 5, loadData unchanged. Ack in cycle 4 instead -> normal completion, no busError.
- Reset pulse in cycle 2 of an outstanding SW (ack withheld) -> memReq, busy, done all 0 immediately. A later LW completes normally.
